crypto_wallet_pi_gpio_out: RTL and testbench
============================================

Name: crypto_wallet_pi_gpio_out

Overview:
Avalon-MM slave output PIO that drives GPIO lines toward the Raspberry Pi header. It is the output-direction counterpart of the Pi input PIO. Provides a directly writable data register, atomic bit-set/bit-clear, and a one-shot timed pulse engine, so firmware can issue strobe/handshake pulses to the Pi without software timing loops. Sits on the Nios data master beside the input PIOs, with out_port exported to the top level.

Parameters:
WIDTH, 2, number of output bits (1..32)
RESET_VALUE, 0, out_port value after reset
PULSE_W, 16, width of pulse length register and counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  WIDTH  GPIO outputs to Pi

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (reset). Reset values: out_port=RESET_VALUE, readdata=0, pulse_len=0, pulse_mask=0, counter=0, FSM=IDLE.
- Write occurs on a clock edge when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used, except PULSE_LEN, which uses [PULSE_W-1:0].
- Register map:
  - 0 DATA (rw): write sets out_port=wd. Read returns out_port.
  - 1 PULSE_LEN (rw): cycles a pulse stays high. Read is zero-extended.
  - 2 PULSE (w/r): write starts or aborts a pulse. Read returns {busy at bit 31, zeros, pulse_mask}.
  - 4 OUTSET (w): out_port |= wd.
  - 5 OUTCLEAR (w): out_port &= ~wd.
  - 3, 6, 7: writes ignored, reads return 0.
- Read latency: readdata is updated every clock from the address mux, regardless of chipselect. Data appears one cycle after the address is presented. Read has no side effects.
- FSM states: IDLE, PULSE.
  - IDLE, PULSE write with mask!=0 and pulse_len!=0: out_port |= mask, latch pulse_mask=mask, counter=pulse_len, go to PULSE.
  - IDLE, PULSE write with mask=0 or pulse_len=0: no effect.
  - PULSE, each cycle: counter decrements. When counter==1: out_port &= ~pulse_mask, pulse_mask=0, go to IDLE. Result: masked bits are high for exactly pulse_len cycles.
  - PULSE, PULSE write with mask=0: abort. Same cycle clears out_port & pulse_mask, pulse_mask=0, go to IDLE.
  - PULSE, PULSE write with mask!=0: ignored. No restart, no extension.
- busy = (state==PULSE).
- Writing PULSE_LEN during PULSE updates the register only. The running counter is unaffected.
- Simultaneous events: a DATA, OUTSET, or OUTCLEAR write in the same cycle as pulse termination or abort is applied first, then pulse_mask bits are cleared. Masked bits end at 0. Non-masked bits take the written value.
- DATA, OUTSET, and OUTCLEAR writes during PULSE act on all bits, including masked bits. Termination still clears the masked bits.
- Counter width: PULSE_W, no wrap. Maximum pulse is 2^PULSE_W-1 cycles.
- Reset asserted mid-pulse: all state returns to reset values on that edge, and out_port goes to RESET_VALUE.

Test Plan:
- Reset then idle: assert reset 3 cycles -> out_port=0, readdata=0. Read addr 0 -> readdata=0 one cycle after the address.
- Set/clear: write DATA=2'b01, OUTSET=2'b10, OUTCLEAR=2'b01 -> out_port goes 01, 11, 10 on successive edges. Read addr 0 -> 0x2.
- Pulse timing: PULSE_LEN=5, PULSE=2'b10 with out_port=00 -> out_port[1]=1 for exactly 5 cycles then 0. Read addr 2 during the pulse -> 0x80000002; after the pulse -> 0x0.
- Ignore/abort: PULSE_LEN=100, PULSE=01, then at cycle 10 PULSE=10 -> ignored, out_port=01. At cycle 20 PULSE=0 -> out_port=00 next edge, busy=0.
- Collision: PULSE_LEN=4, PULSE=01; on the termination cycle write DATA=11 -> out_port=10 after that edge.
- Zero and reset cases: PULSE_LEN=0, PULSE=11 -> no change, busy=0. Then PULSE_LEN=50, PULSE=11, reset at cycle 7 -> out_port=00, busy=0, PULSE_LEN reads 0.

Source files
------------

// File: rtl/crypto_wallet_pi_gpio_out_if.sv
// Avalon-MM slave bus bundle for the Pi-facing output PIO.
// Word-addressed register map with 32-bit data and a registered read path.
interface crypto_wallet_pi_gpio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/crypto_wallet_pi_gpio_out.sv
// Output PIO toward the Raspberry Pi header: direct data register, atomic
// set/clear and a one-shot timed pulse engine for strobes and handshakes.
module crypto_wallet_pi_gpio_out #(
  parameter int                 WIDTH       = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 PULSE_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  crypto_wallet_pi_gpio_out_if.slave  bus,
  output logic [WIDTH-1:0]            out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PULSELEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE    = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]   mask_q;
  logic [PULSE_W-1:0] len_q;
  logic [PULSE_W-1:0] cnt_q;
  logic [31:0]        readdata_q;
  logic [31:0]        readdata_d;
  logic [WIDTH-1:0]   out_wr;
  logic               wr;
  logic               pulse_wr;
  logic               pulse_end;
  logic [WIDTH-1:0]   wd;
  logic               unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign pulse_wr  = wr && (bus.address == ADDR_PULSE);
  assign unused_wd = ^bus.writedata;

  // Termination and abort share one path so a colliding register write lands first.
  assign pulse_end = (pulse_wr && (wd == '0)) || (cnt_q == PULSE_W'(1));

  always_comb begin
    out_wr = out_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:   out_wr = wd;
        ADDR_OUTSET: out_wr = out_q | wd;
        ADDR_OUTCLR: out_wr = out_q & ~wd;
        default:     out_wr = out_q;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d[WIDTH-1:0]   = out_q;
      ADDR_PULSELEN: readdata_d[PULSE_W-1:0] = len_q;
      ADDR_PULSE: begin
        readdata_d[WIDTH-1:0] = mask_q;
        readdata_d[31]        = (state_q == ST_PULSE);
      end
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= RESET_VALUE;
      mask_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
      if (wr && (bus.address == ADDR_PULSELEN)) begin
        len_q <= bus.writedata[PULSE_W-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (pulse_wr && (wd != '0) && (len_q != '0)) begin
            out_q   <= out_wr | wd;
            mask_q  <= wd;
            cnt_q   <= len_q;
            state_q <= ST_PULSE;
          end else begin
            out_q <= out_wr;
          end
        end
        ST_PULSE: begin
          if (pulse_end) begin
            out_q   <= out_wr & ~mask_q;
            mask_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            out_q <= out_wr;
            cnt_q <= cnt_q - PULSE_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_q;

endmodule

// File: tb/tb_crypto_wallet_pi_gpio_out.sv
// Bench for the Pi output PIO: directed scenarios followed by random bus
// traffic, all checked against a timestamp-based behavioural model.
module tb_crypto_wallet_pi_gpio_out;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] out_port;

  crypto_wallet_pi_gpio_out_if bus ();

  crypto_wallet_pi_gpio_out #(
    .WIDTH       (2),
    .RESET_VALUE (2'b00),
    .PULSE_W     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  // Model state: a running pulse is described by the cycle number at which it ends.
  logic [1:0]  m_out;
  logic [1:0]  m_mask;
  logic [15:0] m_len;
  bit          m_busy;
  longint      cyc;
  longint      m_end;
  logic [31:0] m_rd;
  int          total  = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 3'd0) r = {30'd0, m_out};
    if (a == 3'd1) r = {16'd0, m_len};
    if (a == 3'd2) r = {m_busy, 29'd0, m_mask};
    return r;
  endfunction

  task automatic model_edge(input bit rst, input logic [2:0] a, input bit w, input logic [31:0] d);
    bit pw;
    if (rst) begin
      m_out = 2'b00; m_mask = 2'b00; m_len = 16'd0; m_busy = 0; m_rd = 32'd0; cyc = 0; m_end = 0;
    end else begin
      m_rd = model_read(a);
      cyc++;
      pw = w && (a == 3'd2);
      if (w && a == 3'd0) m_out = d[1:0];
      if (w && a == 3'd1) m_len = d[15:0];
      if (w && a == 3'd4) m_out = m_out | d[1:0];
      if (w && a == 3'd5) m_out = m_out & ~d[1:0];
      if (!m_busy) begin
        if (pw && d[1:0] != 2'b00 && m_len != 16'd0) begin
          m_out  = m_out | d[1:0];
          m_mask = d[1:0];
          m_end  = cyc + longint'(m_len);
          m_busy = 1;
        end
      end else if ((pw && d[1:0] == 2'b00) || cyc == m_end) begin
        m_out  = m_out & ~m_mask;
        m_mask = 2'b00;
        m_busy = 0;
      end
    end
  endtask

  task automatic tick(input bit rst, input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] d);
    reset          = rst;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = d;
    @(posedge clk);
    model_edge(rst, a, cs && !wn, d);
    #1;
    chk("out_port", {30'd0, out_port}, {30'd0, m_out});
    chk("readdata", bus.readdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick(0, a, 1'b1, 1'b0, d);
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    for (int k = 0; k < n; k++) tick(0, a, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    int hi;
    logic [2:0]  ra;
    logic [31:0] rd;
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    reset = 1'b1;

    // Reset then idle read
    for (int k = 0; k < 3; k++) tick(1, 3'd0, 1'b0, 1'b1, 32'd0);
    chk("reset_out", {30'd0, out_port}, 32'd0);
    chk("reset_rd", bus.readdata, 32'd0);
    idle(3'd0, 1);
    chk("read_data0", bus.readdata, 32'd0);

    // Set / clear sequence
    wr(3'd0, 32'h1); chk("data_wr", {30'd0, out_port}, 32'h1);
    wr(3'd4, 32'h2); chk("outset", {30'd0, out_port}, 32'h3);
    wr(3'd5, 32'h1); chk("outclear", {30'd0, out_port}, 32'h2);
    idle(3'd0, 1);   chk("read_data2", bus.readdata, 32'h2);

    // Pulse timing
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h2);
    chk("pulse_start", {30'd0, out_port}, 32'h2);
    hi = 1;
    for (int k = 0; k < 8; k++) begin
      idle(3'd2, 1);
      if (out_port[1]) hi++;
      if (k == 0) chk("pulse_status", bus.readdata, 32'h8000_0002);
    end
    chk("pulse_width", hi, 5);
    chk("pulse_status_after", bus.readdata, 32'h0);

    // Ignore and abort
    wr(3'd1, 32'd100);
    wr(3'd2, 32'h1);
    idle(3'd0, 9);
    wr(3'd2, 32'h2);
    chk("pulse_ignore", {30'd0, out_port}, 32'h1);
    idle(3'd0, 9);
    wr(3'd2, 32'h0);
    chk("pulse_abort", {30'd0, out_port}, 32'h0);
    idle(3'd2, 1);
    chk("abort_busy", bus.readdata, 32'h0);

    // Write colliding with termination
    wr(3'd1, 32'd4);
    wr(3'd2, 32'h1);
    idle(3'd0, 3);
    wr(3'd0, 32'h3);
    chk("collision", {30'd0, out_port}, 32'h2);

    // Zero length, then reset mid-pulse
    wr(3'd1, 32'd0);
    wr(3'd2, 32'h3);
    chk("zero_len_out", {30'd0, out_port}, 32'h2);
    idle(3'd2, 1);
    chk("zero_len_busy", bus.readdata, 32'h0);
    wr(3'd1, 32'd50);
    wr(3'd2, 32'h3);
    idle(3'd0, 6);
    tick(1, 3'd0, 1'b0, 1'b1, 32'd0);
    chk("reset_mid_out", {30'd0, out_port}, 32'h0);
    idle(3'd1, 1);
    chk("reset_len", bus.readdata, 32'h0);
    idle(3'd2, 1);
    chk("reset_busy", bus.readdata, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (ra == 3'd1 && $urandom_range(0, 3) != 0) rd = $urandom_range(0, 12);
      if (ra == 3'd2 && $urandom_range(0, 2) == 0) rd = 32'd0;
      tick($urandom_range(0, 99) == 0, ra, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, rd);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
